// File: rtl/ram_bus_ctrl.sv
// Request-driven controller for a single-port synchronous RAM. Sequences the
// RAM strobes, owns the shared tristate data bus with a turnaround cycle after
// reads, and returns read data through a one-entry response register.
module ram_bus_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_busy,
  output logic [ADDR_WIDTH-1:0] o_ram_address,
  inout  wire  [DATA_WIDTH-1:0] io_ram_data,
  output logic                  o_ram_cs,
  output logic                  o_ram_we,
  output logic                  o_ram_oe
);

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd1,
    StRd2,
    StTurn
  } state_e;

  state_e                r_state;
  logic                  r_cs;
  logic                  r_we;
  logic                  r_oe;
  logic                  r_drive;
  logic [ADDR_WIDTH-1:0] r_address;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  w_req_ready;
  logic                  w_accept;

  // Acceptance depends only on registered state, never on the request itself.
  always_comb begin
    w_req_ready = (r_state == StIdle) && !r_rsp_valid;
    w_accept    = i_req_valid && w_req_ready;
  end

  // FSM with registered strobes; outputs are set for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cs        <= 1'b0;
      r_we        <= 1'b0;
      r_oe        <= 1'b0;
      r_drive     <= 1'b0;
      r_address   <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      // The response is only ever held outside RD2, so this never races the capture.
      if (r_rsp_valid && i_rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_address <= i_req_addr;
            r_wdata   <= i_req_wdata;
            r_cs      <= 1'b1;
            if (i_req_we) begin
              r_state <= StWr;
              r_we    <= 1'b1;
              r_oe    <= 1'b0;
              r_drive <= 1'b1;
            end else begin
              r_state <= StRd1;
              r_we    <= 1'b0;
              r_oe    <= 1'b1;
              r_drive <= 1'b0;
            end
          end
        end
        StWr: begin
          r_state <= StIdle;
          r_cs    <= 1'b0;
          r_we    <= 1'b0;
          r_drive <= 1'b0;
        end
        StRd1: begin
          r_state <= StRd2;
        end
        StRd2: begin
          // RAM is driving the word it sampled at the end of RD1.
          r_rsp_rdata <= io_ram_data;
          r_rsp_valid <= 1'b1;
          r_state     <= StTurn;
          r_cs        <= 1'b0;
          r_oe        <= 1'b0;
        end
        StTurn: begin
          // Dead cycle so the RAM output is off before we may drive again.
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
          r_cs    <= 1'b0;
          r_we    <= 1'b0;
          r_oe    <= 1'b0;
          r_drive <= 1'b0;
        end
      endcase
    end
  end

  assign io_ram_data   = r_drive ? r_wdata : {DATA_WIDTH{1'bz}};
  assign o_req_ready   = w_req_ready;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_busy        = (r_state != StIdle);
  assign o_ram_address = r_address;
  assign o_ram_cs      = r_cs;
  assign o_ram_we      = r_we;
  assign o_ram_oe      = r_oe;

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// Bench for ram_bus_ctrl with a behavioural single-port synchronous RAM on the bus.
module tb_ram_bus_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic [7:0] ram_address;
  wire  [7:0] ram_data;
  logic       ram_cs;
  logic       ram_we;
  logic       ram_oe;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  ram_bus_ctrl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_rdata  (rsp_rdata),
    .o_busy       (busy),
    .o_ram_address(ram_address),
    .io_ram_data  (ram_data),
    .o_ram_cs     (ram_cs),
    .o_ram_we     (ram_we),
    .o_ram_oe     (ram_oe)
  );

  // RAM model: writes and read-samples on the rising edge, drives when cs&oe&!we.
  logic [7:0] mem [256];
  logic [7:0] ram_dout;
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_address] <= ram_data;
    if (ram_cs && ram_oe && !ram_we) ram_dout <= mem[ram_address];
  end
  assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_dout : 8'bzzzzzzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Contention monitor: controller must never drive while the RAM outputs.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("bus_contention", {31'd0, dut.r_drive && ram_cs && ram_oe && !ram_we}, 32'd0);
      if (dut.r_drive || (ram_cs && ram_oe && !ram_we))
        chk("bus_no_x", {31'd0, $isunknown(ram_data)}, 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic we, input logic [7:0] a, input logic [7:0] d,
                      output int acc);
    int budget;
    budget    = 20;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    acc       = cyc;
    req_valid = 1'b0;
  endtask

  // Waits for the read response, checks latency and data, then consumes it.
  task automatic get_rsp(input int acc, input logic [7:0] exp, input string name);
    int budget;
    budget = 10;
    while (!rsp_valid && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    chk({name, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({name, "_latency"}, cyc - acc, 32'd2);
    chk({name, "_rdata"}, {24'd0, rsp_rdata}, {24'd0, exp});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({name, "_rsp_cleared"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [8];
  int   acc;
  int   acc2;

  initial begin
    tbl[0] = '{we: 1'b1, addr: 8'h01, wdata: 8'hAA, exp: 8'h00};
    tbl[1] = '{we: 1'b0, addr: 8'h01, wdata: 8'h00, exp: 8'hAA};
    tbl[2] = '{we: 1'b0, addr: 8'h00, wdata: 8'h00, exp: 8'h11};
    tbl[3] = '{we: 1'b0, addr: 8'hFF, wdata: 8'h00, exp: 8'h22};
    tbl[4] = '{we: 1'b1, addr: 8'h80, wdata: 8'h5C, exp: 8'h00};
    tbl[5] = '{we: 1'b0, addr: 8'h80, wdata: 8'h00, exp: 8'h5C};
    tbl[6] = '{we: 1'b1, addr: 8'hFF, wdata: 8'hC3, exp: 8'h00};
    tbl[7] = '{we: 1'b0, addr: 8'hFF, wdata: 8'h00, exp: 8'hC3};

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 8'h00;
    rsp_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_strobes", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
    chk("rst_address", {24'd0, ram_address}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_bus_released", {31'd0, dut.r_drive}, 32'd0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // Back-to-back writes with req_valid held high
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h00; req_wdata = 8'h11;
    @(posedge clk); #1;
    acc = cyc;
    chk("b2b_w0_strobes", {29'd0, ram_cs, ram_we, ram_oe}, 32'b110);
    chk("b2b_w0_addr", {24'd0, ram_address}, 32'h00);
    chk("b2b_w0_busy", {31'd0, busy}, 32'd1);
    req_addr = 8'hFF; req_wdata = 8'h22;
    chk("b2b_wr_not_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("b2b_wr_done_strobes", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_w1_strobes", {29'd0, ram_cs, ram_we, ram_oe}, 32'b110);
    chk("b2b_w1_addr", {24'd0, ram_address}, 32'hFF);
    chk("b2b_w1_data", {24'd0, ram_data}, 32'h22);
    chk("b2b_w1_spacing", cyc - acc, 32'd2);
    @(posedge clk); #1;

    // Table-driven transactions
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].we, tbl[i].addr, tbl[i].wdata, acc);
      chk($sformatf("v%0d_addr", i), {24'd0, ram_address}, {24'd0, tbl[i].addr});
      if (tbl[i].we) begin
        chk($sformatf("v%0d_wr_strobes", i), {29'd0, ram_cs, ram_we, ram_oe}, 32'b110);
        chk($sformatf("v%0d_wr_data", i), {24'd0, ram_data}, {24'd0, tbl[i].wdata});
        @(posedge clk); #1;
        chk($sformatf("v%0d_wr_one_cycle", i), {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
        chk($sformatf("v%0d_wr_ready_after", i), {31'd0, req_ready}, 32'd1);
      end else begin
        chk($sformatf("v%0d_rd1_strobes", i), {29'd0, ram_cs, ram_we, ram_oe}, 32'b101);
        get_rsp(acc, tbl[i].exp, $sformatf("v%0d", i));
      end
    end

    // Response stall: held data is stable and no request is accepted
    send(1'b0, 8'h01, 8'h00, acc);
    get_rsp_wait: begin
      int budget;
      budget = 10;
      while (!rsp_valid && budget > 0) begin
        @(posedge clk); #1;
        budget--;
      end
    end
    chk("stall_latency", cyc - acc, 32'd2);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h02; req_wdata = 8'h33;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_rsp_valid", k), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("stall%0d_rdata", k), {24'd0, rsp_rdata}, 32'hAA);
      chk($sformatf("stall%0d_req_ready", k), {31'd0, req_ready}, 32'd0);
      chk($sformatf("stall%0d_strobes", k), {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("stall_consumed", {31'd0, rsp_valid}, 32'd0);
    chk("stall_rdata_kept", {24'd0, rsp_rdata}, 32'hAA);
    chk("stall_ready_next", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("stall_write_accepted", {29'd0, ram_cs, ram_we, ram_oe}, 32'b110);
    chk("stall_write_addr", {24'd0, ram_address}, 32'h02);
    @(posedge clk); #1;

    // Read immediately followed by a write: TURN cycle must separate them
    rsp_ready = 1'b1;
    send(1'b0, 8'h01, 8'h00, acc);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h03; req_wdata = 8'h44;
    @(posedge clk); #1;
    chk("rw_rd2_strobes", {29'd0, ram_cs, ram_we, ram_oe}, 32'b101);
    @(posedge clk); #1;
    chk("rw_turn_strobes", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
    chk("rw_turn_busy", {31'd0, busy}, 32'd1);
    chk("rw_turn_no_drive", {31'd0, dut.r_drive}, 32'd0);
    chk("rw_turn_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rw_turn_rdata", {24'd0, rsp_rdata}, 32'hAA);
    chk("rw_turn_not_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rw_idle_rsp_gone", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("rw_write_strobes", {29'd0, ram_cs, ram_we, ram_oe}, 32'b110);
    chk("rw_write_spacing", cyc - acc, 32'd4);
    @(posedge clk); #1;
    send(1'b0, 8'h03, 8'h00, acc);
    get_rsp(acc, 8'h44, "rw_readback");

    // Reset asserted during RD2
    send(1'b0, 8'h02, 8'h00, acc);
    @(posedge clk); #1;
    chk("rst_rd2_strobes_before", {29'd0, ram_cs, ram_we, ram_oe}, 32'b101);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rd2_strobes", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
    chk("rst_rd2_no_drive", {31'd0, dut.r_drive}, 32'd0);
    chk("rst_rd2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rd2_busy", {31'd0, busy}, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rd2_ready_after", {31'd0, req_ready}, 32'd1);
    chk("rst_rd2_no_rsp", {31'd0, rsp_valid}, 32'd0);
    send(1'b0, 8'h01, 8'h00, acc2);
    get_rsp(acc2, 8'hAA, "post_rst_read");

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
